// File: rtl/tm_pkg.sv
// tm_pkg -- shared definitions for the transaction-monitor tracker.
//
// Purpose: common constants, the length type and the update-FSM state
// encoding used by tm_tracker and tm_len_counter.
//
// Contents:
//   TM_ALU_LAT      running-average ALU pipeline depth (clock edges)
//   TM_LEN_W        width of lengths, averages and counts
//   tm_len_t        length/average/count type
//   tm_upd_state_t  update FSM states (U_IDLE, U_WAIT)
package tm_pkg;

  localparam int TM_ALU_LAT = 4;
  localparam int TM_LEN_W   = 8;

  typedef logic [TM_LEN_W-1:0] tm_len_t;

  typedef enum logic {
    U_IDLE = 1'b0,
    U_WAIT = 1'b1
  } tm_upd_state_t;

endpackage

// File: rtl/tm_len_counter.sv
// tm_len_counter -- measures bus transaction length in clock cycles.
//
// Purpose: tracks whether a transaction is open and how many cycles it has
// lasted so far (saturating), and flags completions and abandonments.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   tx_start  in   transaction begins this cycle
//   tx_end    in   transaction ends this cycle
//   done      out  a measurement completes this cycle (combinational)
//   done_len  out  measured length, valid with done (combinational)
//   abandon   out  an open transaction is abandoned by a new tx_start
module tm_len_counter
  import tm_pkg::*;
#(
  parameter int LEN_W = TM_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_start,
  input  logic             tx_end,
  output logic             done,
  output logic [LEN_W-1:0] done_len,
  output logic             abandon
);

  logic             open;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_inc;

  // Length including the current cycle, pinned at the all-ones maximum.
  assign len_inc = (len == {LEN_W{1'b1}}) ? len : len + LEN_W'(1);

  // A tx_start always begins a fresh length of 1, so a start+end in the
  // same cycle completes with length 1 even if an older transaction was open.
  assign done     = tx_end & (tx_start | open);
  assign done_len = tx_start ? LEN_W'(1) : len_inc;
  assign abandon  = tx_start & open;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open <= 1'b0;
      len  <= '0;
    end else if (tx_start) begin
      open <= ~tx_end;
      len  <= LEN_W'(1);
    end else if (open) begin
      if (tx_end) begin
        open <= 1'b0;
      end else begin
        len <= len_inc;
      end
    end
  end

endmodule

// File: rtl/tm_tracker.sv
// tm_tracker -- transaction-length tracker feeding the running-average ALU.
//
// Purpose: measures each bus transaction, issues {AvgTxLen, InstExed,
// CurTxLen} to the external ALU, waits out its pipeline latency and commits
// AvgTxLen_new/InstExed_new into avg_len/inst_cnt. Completions that arrive
// while an update is in flight, or once inst_cnt is saturated, are dropped.
//
// Configuration macro: TM_TRACKER_DROP_CNT_EN
//   defined   -> drop_cnt counts dropped/abandoned transactions (saturating)
//   undefined -> drop_cnt is tied to 0; drop behaviour is otherwise the same
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   tx_start      in   transaction begins this cycle
//   tx_end        in   transaction ends this cycle
//   AvgTxLen      out  ALU operand: committed average at issue time
//   InstExed      out  ALU operand: committed count at issue time
//   CurTxLen      out  ALU operand: length just measured
//   AvgTxLen_new  in   ALU result: new average
//   InstExed_new  in   ALU result: new count
//   avg_len       out  committed average transaction length
//   inst_cnt      out  committed transaction count
//   busy          out  update in flight
//   drop_cnt      out  transactions not folded into the average
module tm_tracker
  import tm_pkg::*;
#(
  parameter int ALU_LAT = TM_ALU_LAT,
  parameter int LEN_W   = TM_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_start,
  input  logic             tx_end,
  output logic [LEN_W-1:0] AvgTxLen,
  output logic [LEN_W-1:0] InstExed,
  output logic [LEN_W-1:0] CurTxLen,
  input  logic [LEN_W-1:0] AvgTxLen_new,
  input  logic [LEN_W-1:0] InstExed_new,
  output logic [LEN_W-1:0] avg_len,
  output logic [LEN_W-1:0] inst_cnt,
  output logic             busy,
  output logic [LEN_W-1:0] drop_cnt
);

  localparam int               CNT_W  = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(ALU_LAT);

  tm_upd_state_t    state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             issue;
  logic             commit;
  logic             full;
  logic             done;
  logic [LEN_W-1:0] done_len;
  logic             abandon;

  tm_len_counter #(
    .LEN_W (LEN_W)
  ) u_len_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_start (tx_start),
    .tx_end   (tx_end),
    .done     (done),
    .done_len (done_len),
    .abandon  (abandon)
  );

  // Issuing once more at the maximum count would make the ALU's
  // InstExed+1 wrap to zero and divide by zero.
  assign full = (inst_cnt == {LEN_W{1'b1}});
  assign busy = (state == U_WAIT);

  // Commit fires on the edge after wait_cnt reaches 0, i.e. ALU_LAT+1 edges
  // after issue, which is one edge after the ALU result becomes valid.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    issue         = 1'b0;
    commit        = 1'b0;
    case (state)
      U_IDLE: begin
        if (done && !full) begin
          issue         = 1'b1;
          wait_cnt_next = LAT_LD;
          state_next    = U_WAIT;
        end
      end
      U_WAIT: begin
        if (wait_cnt == '0) begin
          commit     = 1'b1;
          state_next = U_IDLE;
        end else begin
          wait_cnt_next = wait_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = U_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= U_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Operands are only loaded on issue, so they stay stable through U_WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      AvgTxLen <= '0;
      InstExed <= '0;
      CurTxLen <= '0;
    end else if (issue) begin
      AvgTxLen <= avg_len;
      InstExed <= inst_cnt;
      CurTxLen <= done_len;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avg_len  <= '0;
      inst_cnt <= '0;
    end else if (commit) begin
      avg_len  <= AvgTxLen_new;
      inst_cnt <= InstExed_new;
    end
  end

`ifdef TM_TRACKER_DROP_CNT_EN
  logic             drop_evt;
  logic [1:0]       drop_inc;
  logic [LEN_W:0]   drop_sum;

  // An abandon and a refused completion can coincide, so up to two drops
  // may be added on one edge.
  assign drop_evt = done & (busy | full);
  assign drop_inc = {1'b0, abandon} + {1'b0, drop_evt};
  assign drop_sum = {1'b0, drop_cnt} + (LEN_W+1)'(drop_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop_sum[LEN_W]) begin
      drop_cnt <= {LEN_W{1'b1}};
    end else begin
      drop_cnt <= drop_sum[LEN_W-1:0];
    end
  end
`else
  // Without the counter the abandon strobe has no consumer.
  logic unused_abandon;
  assign unused_abandon = abandon;
  assign drop_cnt       = '0;
`endif

endmodule

// File: tb/tb_tm_tracker.sv
// tb_tm_tracker -- self-checking bench for tm_tracker with a behavioural
// 4-stage running-average ALU beside it.
// Macro TM_TRACKER_DROP_CNT_EN selects the expected drop_cnt behaviour.
module tb_tm_tracker;
  import tm_pkg::*;

  localparam int LAT = TM_ALU_LAT;

  logic    clk = 1'b0;
  logic    reset_n = 1'b0;
  logic    tx_start = 1'b0;
  logic    tx_end = 1'b0;
  tm_len_t AvgTxLen, InstExed, CurTxLen;
  tm_len_t AvgTxLen_new, InstExed_new;
  tm_len_t avg_len, inst_cnt, drop_cnt;
  logic    busy;

  int tests_run = 0;
  int fail_count = 0;
  int cyc = 0;

  // Reference model state (committed values and last accepted end edge).
  int m_avg, m_cnt, m_drop, m_last_acc;
  int op_avg, op_cnt, op_cur;

  always #5 clk = ~clk;

  tm_tracker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx_start     (tx_start),
    .tx_end       (tx_end),
    .AvgTxLen     (AvgTxLen),
    .InstExed     (InstExed),
    .CurTxLen     (CurTxLen),
    .AvgTxLen_new (AvgTxLen_new),
    .InstExed_new (InstExed_new),
    .avg_len      (avg_len),
    .inst_cnt     (inst_cnt),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  // Behavioural ALU: captures operands every edge, result after LAT edges.
  tm_len_t pipe_avg[LAT];
  tm_len_t pipe_cnt[LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_avg[i] <= pipe_avg[i-1];
      pipe_cnt[i] <= pipe_cnt[i-1];
    end
    pipe_avg[0] <= tm_len_t'((int'(AvgTxLen) * int'(InstExed) + int'(CurTxLen)) / (int'(InstExed) + 1));
    pipe_cnt[0] <= tm_len_t'(int'(InstExed) + 1);
  end
  assign AvgTxLen_new = pipe_avg[LAT-1];
  assign InstExed_new = pipe_cnt[LAT-1];

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic int exp_drop();
`ifdef TM_TRACKER_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic model_reset();
    m_avg = 0; m_cnt = 0; m_drop = 0; m_last_acc = -1000;
  endtask

  task automatic model_drop();
    if (m_drop < 255) m_drop++;
  endtask

  // Applies the completion rules to a measurement ending at the current edge.
  task automatic model_complete(input int raw_len, output bit acc);
    int l;
    l = (raw_len > 255) ? 255 : raw_len;
    if ((cyc - m_last_acc) <= LAT + 1 || m_cnt == 255) begin
      model_drop();
      acc = 1'b0;
    end else begin
      op_avg = m_avg; op_cnt = m_cnt; op_cur = l;
      m_avg = (m_avg * m_cnt + l) / (m_cnt + 1);
      m_cnt++;
      m_last_acc = cyc;
      acc = 1'b1;
    end
  endtask

  task automatic apply_reset();
    tx_start = 1'b0; tx_end = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic do_tx(input int len, output bit acc);
    tx_start = 1'b1;
    tx_end = (len == 1);
    tick();
    tx_start = 1'b0;
    tx_end = 1'b0;
    if (len > 1) begin
      repeat (len - 2) tick();
      tx_end = 1'b1;
      tick();
      tx_end = 1'b0;
    end
    model_complete(len, acc);
  endtask

  task automatic wait_idle();
    repeat (LAT + 3) tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (avg_len !== 8'd0) begin fail_count++; $display("[TB] FAIL reset_avg_len: got %0d want 0", avg_len); end
    tests_run++; if (inst_cnt !== 8'd0) begin fail_count++; $display("[TB] FAIL reset_inst_cnt: got %0d want 0", inst_cnt); end
    tests_run++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_busy: got %0d want 0", busy); end
    tests_run++; if (drop_cnt !== 8'd0) begin fail_count++; $display("[TB] FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    tests_run++; if ({AvgTxLen, InstExed, CurTxLen} !== 24'd0) begin fail_count++; $display("[TB] FAIL reset_operands: got %0d/%0d/%0d want 0/0/0", AvgTxLen, InstExed, CurTxLen); end
  endtask

  task automatic test_basic();
    int lens[3] = '{10, 20, 6};
    int want_avg[3] = '{10, 15, 12};
    bit acc;
    int n;
    for (int k = 0; k < 3; k++) begin
      do_tx(lens[k], acc);
      tests_run++; if (acc !== 1'b1) begin fail_count++; $display("[TB] FAIL basic_accept[%0d]: got %0d want 1", k, acc); end
      tests_run++; if (CurTxLen !== 8'(op_cur) || AvgTxLen !== 8'(op_avg) || InstExed !== 8'(op_cnt)) begin
        fail_count++; $display("[TB] FAIL basic_operands[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", k, AvgTxLen, InstExed, CurTxLen, op_avg, op_cnt, op_cur);
      end
      n = 0;
      while (busy === 1'b1 && n < 20) begin
        n++;
        tests_run++; if (CurTxLen !== 8'(op_cur) || AvgTxLen !== 8'(op_avg)) begin fail_count++; $display("[TB] FAIL basic_hold[%0d]: got %0d/%0d want %0d/%0d", k, AvgTxLen, CurTxLen, op_avg, op_cur); end
        tick();
      end
      tests_run++; if (n != LAT + 1) begin fail_count++; $display("[TB] FAIL basic_busy_len[%0d]: got %0d want %0d", k, n, LAT + 1); end
      tests_run++; if (avg_len !== 8'(m_avg) || m_avg != want_avg[k]) begin fail_count++; $display("[TB] FAIL basic_avg[%0d]: got %0d want %0d", k, avg_len, want_avg[k]); end
      tests_run++; if (inst_cnt !== 8'(k + 1)) begin fail_count++; $display("[TB] FAIL basic_cnt[%0d]: got %0d want %0d", k, inst_cnt, k + 1); end
      tick(); tick();
    end
  endtask

  task automatic test_lengths();
    bit acc;
    do_tx(1, acc);
    tests_run++; if (acc !== 1'b1 || CurTxLen !== 8'd1) begin fail_count++; $display("[TB] FAIL len_one: got %0d want 1", CurTxLen); end
    wait_idle();
    do_tx(300, acc);
    tests_run++; if (acc !== 1'b1 || CurTxLen !== 8'd255) begin fail_count++; $display("[TB] FAIL len_sat: got %0d want 255", CurTxLen); end
    wait_idle();
    tests_run++; if (avg_len !== 8'(m_avg) || inst_cnt !== 8'(m_cnt)) begin fail_count++; $display("[TB] FAIL len_commit: got %0d/%0d want %0d/%0d", avg_len, inst_cnt, m_avg, m_cnt); end
  endtask

  task automatic test_back_to_back();
    bit acc1, acc2;
    int avg_before;
    apply_reset();
    do_tx(1, acc1);
    avg_before = m_avg;
    tick();
    do_tx(1, acc2);
    tests_run++; if (acc1 !== 1'b1 || acc2 !== 1'b0) begin fail_count++; $display("[TB] FAIL b2b_model: got %0d%0d want 10", acc1, acc2); end
    wait_idle();
    tests_run++; if (avg_len !== 8'd1 || inst_cnt !== 8'd1) begin fail_count++; $display("[TB] FAIL b2b_commit: got %0d/%0d want 1/1 (model %0d)", avg_len, inst_cnt, avg_before); end
    tests_run++; if (drop_cnt !== 8'(exp_drop())) begin fail_count++; $display("[TB] FAIL b2b_drop: got %0d want %0d", drop_cnt, exp_drop()); end
  endtask

  task automatic test_abandon();
    bit acc;
    tx_start = 1'b1; tick();
    tx_start = 1'b0; tick(); tick();
    tx_start = 1'b1; tick();
    model_drop();
    tx_start = 1'b0; tick();
    tx_end = 1'b1; tick();
    tx_end = 1'b0;
    model_complete(3, acc);
    tests_run++; if (busy !== acc || (acc && CurTxLen !== 8'd3)) begin fail_count++; $display("[TB] FAIL abandon_len: got busy %0d len %0d want busy %0d len 3", busy, CurTxLen, acc); end
    wait_idle();
    tests_run++; if (drop_cnt !== 8'(exp_drop()) || avg_len !== 8'(m_avg)) begin fail_count++; $display("[TB] FAIL abandon_state: got %0d/%0d want %0d/%0d", drop_cnt, avg_len, exp_drop(), m_avg); end
  endtask

  task automatic test_reset_mid_wait();
    bit acc;
    do_tx(5, acc);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    tests_run++; if ({avg_len, inst_cnt, drop_cnt, CurTxLen, AvgTxLen, InstExed} !== 48'd0 || busy !== 1'b0) begin
      fail_count++; $display("[TB] FAIL rst_async: got avg %0d cnt %0d drop %0d busy %0d want zeros", avg_len, inst_cnt, drop_cnt, busy);
    end
    tick(); tick();
    reset_n = 1'b1;
    model_reset();
    repeat (10) tick();
    tests_run++; if ({avg_len, inst_cnt, drop_cnt} !== 24'd0 || busy !== 1'b0) begin
      fail_count++; $display("[TB] FAIL rst_no_late_commit: got avg %0d cnt %0d drop %0d busy %0d want zeros", avg_len, inst_cnt, drop_cnt, busy);
    end
  endtask

  task automatic test_random();
    bit acc;
    int len, gap;
    apply_reset();
    for (int k = 0; k < 60; k++) begin
      len = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(1, 40));
      gap = $urandom_range(0, 8);
      do_tx(len, acc);
      if (acc) begin
        tests_run++; if (busy !== 1'b1 || CurTxLen !== 8'(op_cur) || AvgTxLen !== 8'(op_avg) || InstExed !== 8'(op_cnt)) begin
          fail_count++; $display("[TB] FAIL rand_issue[%0d]: got %0d/%0d/%0d busy %0d want %0d/%0d/%0d", k, AvgTxLen, InstExed, CurTxLen, busy, op_avg, op_cnt, op_cur);
        end
      end
      repeat (gap) tick();
    end
    wait_idle();
    tests_run++; if (avg_len !== 8'(m_avg) || inst_cnt !== 8'(m_cnt)) begin fail_count++; $display("[TB] FAIL rand_commit: got %0d/%0d want %0d/%0d", avg_len, inst_cnt, m_avg, m_cnt); end
    tests_run++; if (drop_cnt !== 8'(exp_drop())) begin fail_count++; $display("[TB] FAIL rand_drop: got %0d want %0d", drop_cnt, exp_drop()); end
  endtask

  task automatic test_full();
    bit acc;
    int drop_before;
    apply_reset();
    for (int k = 0; k < 255; k++) begin
      do_tx(4, acc);
      tick(); tick();
    end
    wait_idle();
    tests_run++; if (inst_cnt !== 8'd255 || avg_len !== 8'd4) begin fail_count++; $display("[TB] FAIL full_preload: got %0d/%0d want 4/255", avg_len, inst_cnt); end
    drop_before = exp_drop();
    do_tx(4, acc);
    tests_run++; if (busy !== 1'b0 || acc !== 1'b0) begin fail_count++; $display("[TB] FAIL full_no_issue: got busy %0d want 0", busy); end
    wait_idle();
    tests_run++; if (inst_cnt !== 8'd255 || avg_len !== 8'd4) begin fail_count++; $display("[TB] FAIL full_hold: got %0d/%0d want 4/255", avg_len, inst_cnt); end
    tests_run++; if (drop_cnt !== 8'(exp_drop())) begin fail_count++; $display("[TB] FAIL full_drop: got %0d want %0d (before %0d)", drop_cnt, exp_drop(), drop_before); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_lengths();
    test_back_to_back();
    test_abandon();
    test_reset_mid_wait();
    test_random();
    test_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/tm_tracker.md
# tm_tracker

Transaction-length tracker: the issuing and consuming end of the transaction-monitor ALU. It measures the length of each bus transaction in clock cycles and drives {AvgTxLen, InstExed, CurTxLen} into the 4-stage running-average ALU. It waits out the pipeline latency, then captures AvgTxLen_new/InstExed_new into its architectural state registers. It sits between the bus-event decoder (tx_start/tx_end strobes) and the ALU instance at the monitor top level.

## Interface
- ALU_LAT, 4, ALU pipeline depth in clock edges from operand capture to result valid
- LEN_W, 8, width of lengths, average and instance count
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- tx_start  in  1  single-cycle strobe, transaction begins this cycle
- tx_end  in  1  single-cycle strobe, transaction ends this cycle
- AvgTxLen  out  LEN_W  operand to ALU: current average
- InstExed  out  LEN_W  operand to ALU: current instance count
- CurTxLen  out  LEN_W  operand to ALU: length just measured
- AvgTxLen_new  in  LEN_W  result from ALU
- InstExed_new  in  LEN_W  result from ALU
- avg_len  out  LEN_W  committed average transaction length
- inst_cnt  out  LEN_W  committed transaction count
- busy  out  1  update in flight
- drop_cnt  out  LEN_W  transactions not folded into the average

## Operation
- Reset (async assert, sync release) forces every output, counter and state to 0. The FSM goes to U_IDLE.
- Length measurement (independent of the update FSM):
  - tx_start sets open=1, len=1.
  - Each later edge with open=1 and no tx_end increments len, saturating at 2^LEN_W-1.
  - Measured length = cycles from tx_start to tx_end inclusive. tx_start and tx_end in the same cycle with open=0 gives length 1.
  - tx_start while open=1 abandons the current transaction: drop_cnt+1, len restarts at 1.
  - tx_end with open=0 and no tx_start is ignored.
- Update FSM states U_IDLE, U_WAIT:
  - In U_IDLE, a completed measurement registers AvgTxLen=avg_len, InstExed=inst_cnt, CurTxLen=length and loads wait_cnt=ALU_LAT. State goes to U_WAIT.
  - In U_WAIT, wait_cnt decrements each edge. The edge after it reaches 0 captures avg_len<=AvgTxLen_new and inst_cnt<=InstExed_new, then returns to U_IDLE.
  - Operands are held stable for the whole of U_WAIT.
- busy = (state == U_WAIT).
- Drops, each incrementing drop_cnt (saturating):
  - a transaction completing while busy=1;
  - a transaction completing while inst_cnt == 2^LEN_W-1. No issue is made, because the ALU's InstExed+1 would wrap and divide by zero.
- The ALU result is trusted unchecked: (avg·inst + cur)/(inst+1), with inst=0 giving avg=cur.

## Timing
- tx_end sampled at edge E0: operands and busy=1 are valid after E0. The ALU captures them at E1, and its result is valid after E(ALU_LAT).
- Commit happens at E(ALU_LAT+1). busy falls at the same edge. avg_len/inst_cnt are visible after E5 for the default configuration.
- busy is high for exactly ALU_LAT+1 cycles.
- A tx_end sampled at the commit edge is dropped. The earliest accepted completion is the edge after busy falls.
- Reset mid-U_WAIT: the update is discarded. avg_len, inst_cnt and drop_cnt read 0 after release, and any ALU result still in flight is ignored.

## Configuration
- TM_TRACKER_DROP_CNT_EN defined: drop_cnt is implemented as described.
- Undefined: the counter logic is removed and drop_cnt is tied to 0. Drop behaviour (no issue) is unchanged.

## Structure
- Shared package tm_pkg holds:
  - constants TM_ALU_LAT=4 and TM_LEN_W=8;
  - typedef tm_len_t (logic [TM_LEN_W-1:0]);
  - enum tm_upd_state_t {U_IDLE, U_WAIT}.
- One sub-module, tm_len_counter: open flag, saturating length, completion strobe and abandon strobe.
- The update FSM, operand registers and drop counter stay in tm_tracker.
- The ALU is instantiated beside tm_tracker at the top level, not inside it.

## Test plan
- Reset, then tx_start at cycle 0 and tx_end at cycle 9: busy high for 5 cycles, then avg_len=10 and inst_cnt=1.
- Follow with length 20, then length 6: avg_len=15/inst_cnt=2, then avg_len=12/inst_cnt=3. Check the operands seen on CurTxLen.
- tx_start and tx_end in the same cycle from idle gives CurTxLen=1. A transaction of 300 cycles gives CurTxLen=255.
- Two 1-cycle transactions 2 cycles apart: the second is dropped, drop_cnt=1, avg_len reflects only the first. Repeat with the macro undefined: drop_cnt stays 0.
- Preload to inst_cnt=255 via 255 transactions of length 4: the 256th completes with busy staying 0, avg_len=4 and inst_cnt=255 unchanged, drop_cnt+1.
- Assert reset_n=0 during U_WAIT (2 cycles after tx_end): all outputs are 0 immediately and stay 0 after release, with no late commit.
